// File: rtl/rv32i_encoder.sv
// RV32I instruction encoder: mnemonic index plus register/immediate fields in, 32-bit
// instruction word and IMEM word address out, through a two-stage valid/ready pipeline.
module rv32i_encoder #(
  parameter int ADDR_W    = 10,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [5:0]           i_op,
  input  logic [4:0]           i_rd,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [31:0]          i_imm,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [31:0]          o_instr,
  output logic [ADDR_W-1:0]    o_addr,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  typedef enum logic [3:0] {
    FMT_BAD, FMT_U, FMT_J, FMT_I, FMT_B, FMT_S, FMT_SH, FMT_R, FMT_FENCE, FMT_CSR, FMT_FIXED
  } fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic        s1_valid;
  logic [5:0]  s1_op;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [31:0] s1_imm;

  fmt_e        fmt;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] fixed_word;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        i_ok, b_ok, j_ok;
  logic        stall, handshake;

  assign stall     = o_valid & ~i_out_ready;
  assign o_ready   = ~stall;
  assign handshake = o_valid & i_out_ready;

  // Sign-extension checks: the bits above the field width must all equal the field sign bit.
  assign i_ok = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
  assign b_ok = ((&s1_imm[31:12]) | ~(|s1_imm[31:12])) & ~s1_imm[0];
  assign j_ok = ((&s1_imm[31:20]) | ~(|s1_imm[31:20])) & ~s1_imm[0];

  always_comb begin
    fmt        = FMT_BAD;
    opc        = '0;
    f3         = '0;
    f7         = '0;
    fixed_word = '0;
    case (s1_op)
      6'd0:  begin fmt = FMT_U;  opc = OPC_LUI;    end
      6'd1:  begin fmt = FMT_U;  opc = OPC_AUIPC;  end
      6'd2:  begin fmt = FMT_J;  opc = OPC_JAL;    end
      6'd3:  begin fmt = FMT_I;  opc = OPC_JALR;   end
      6'd4:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd0; end
      6'd5:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd1; end
      6'd6:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd4; end
      6'd7:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd5; end
      6'd8:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd6; end
      6'd9:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd7; end
      6'd10: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd0; end
      6'd11: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd1; end
      6'd12: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd2; end
      6'd13: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd4; end
      6'd14: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd5; end
      6'd15: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd0; end
      6'd16: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd1; end
      6'd17: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd2; end
      6'd18: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd0; end
      6'd19: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd2; end
      6'd20: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd3; end
      6'd21: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd4; end
      6'd22: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd6; end
      6'd23: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd7; end
      6'd24: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'd1; end
      6'd25: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'd5; end
      6'd26: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'd5; f7 = F7_ALT; end
      6'd27: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd0; end
      6'd28: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd0; f7 = F7_ALT; end
      6'd29: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd1; end
      6'd30: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd2; end
      6'd31: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd3; end
      6'd32: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd4; end
      6'd33: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd5; end
      6'd34: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd5; f7 = F7_ALT; end
      6'd35: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd6; end
      6'd36: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd7; end
      6'd37: begin fmt = FMT_FENCE; opc = OPC_FENCE; end
      6'd38: begin fmt = FMT_FIXED; fixed_word = 32'h0000_100F; end
      6'd39: begin fmt = FMT_FIXED; fixed_word = 32'h0000_0073; end
      6'd40: begin fmt = FMT_FIXED; fixed_word = 32'h0010_0073; end
      6'd41: begin fmt = FMT_CSR; opc = OPC_SYSTEM; f3 = 3'd1; end
      6'd42: begin fmt = FMT_CSR; opc = OPC_SYSTEM; f3 = 3'd2; end
      6'd43: begin fmt = FMT_CSR; opc = OPC_SYSTEM; f3 = 3'd3; end
      6'd44: begin fmt = FMT_CSR; opc = OPC_SYSTEM; f3 = 3'd5; end
      6'd45: begin fmt = FMT_CSR; opc = OPC_SYSTEM; f3 = 3'd6; end
      6'd46: begin fmt = FMT_CSR; opc = OPC_SYSTEM; f3 = 3'd7; end
      default: fmt = FMT_BAD;
    endcase
  end

  // Errored words are emitted as all-zero so a bad word can never look like a real instruction.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (fmt)
      FMT_U: begin
        enc_err   = |s1_imm[31:20];
        enc_instr = {s1_imm[19:0], s1_rd, opc};
      end
      FMT_J: begin
        enc_err   = ~j_ok;
        enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, opc};
      end
      FMT_I: begin
        enc_err   = ~i_ok;
        enc_instr = {s1_imm[11:0], s1_rs1, f3, s1_rd, opc};
      end
      FMT_B: begin
        enc_err   = ~b_ok;
        enc_instr = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, f3, s1_imm[4:1], s1_imm[11], opc};
      end
      FMT_S: begin
        enc_err   = ~i_ok;
        enc_instr = {s1_imm[11:5], s1_rs2, s1_rs1, f3, s1_imm[4:0], opc};
      end
      FMT_SH: begin
        enc_err   = |s1_imm[31:5];
        enc_instr = {f7, s1_imm[4:0], s1_rs1, f3, s1_rd, opc};
      end
      FMT_R:     enc_instr = {f7, s1_rs2, s1_rs1, f3, s1_rd, opc};
      FMT_FENCE: enc_instr = {s1_imm[11:0], 5'd0, 3'd0, 5'd0, opc};
      FMT_CSR: begin
        enc_err   = |s1_imm[31:12];
        enc_instr = {s1_imm[11:0], s1_rs1, f3, s1_rd, opc};
      end
      FMT_FIXED: enc_instr = fixed_word;
      default:   enc_err   = 1'b1;
    endcase
    if (enc_err) enc_instr = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_imm   <= '0;
      o_valid  <= 1'b0;
      o_instr  <= '0;
      o_err    <= 1'b0;
    end else if (!stall) begin
      s1_valid <= i_valid;
      s1_op    <= i_op;
      s1_rd    <= i_rd;
      s1_rs1   <= i_rs1;
      s1_rs2   <= i_rs2;
      s1_imm   <= i_imm;
      o_valid  <= s1_valid;
      o_instr  <= s1_valid ? enc_instr : '0;
      o_err    <= s1_valid & enc_err;
    end
  end

  // The address only moves on a handshake, so it stays with its word while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_addr    <= '0;
      o_err_cnt <= '0;
    end else if (i_clear) begin
      o_addr    <= '0;
      o_err_cnt <= '0;
    end else if (handshake) begin
      o_addr <= o_addr + ADDR_W'(1);
      if (o_err && !(&o_err_cnt)) o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32i_encoder.sv
// Self-checking bench for rv32i_encoder: a transaction-level model predicts every output
// cycle by cycle; a second instance with a 2-bit address checks wrap-around.
module tb_rv32i_encoder;

  logic        i_clk, i_rst, i_clear, i_valid, i_out_ready;
  logic [5:0]  i_op;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [31:0] i_imm;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_instr;
  logic [9:0]  o_addr;
  logic [15:0] o_err_cnt;
  logic        o_ready2, o_valid2, o_err2;
  logic [31:0] o_instr2;
  logic [1:0]  o_addr2;
  logic [15:0] o_err_cnt2;

  int errors = 0;
  int checks = 0;

  rv32i_encoder #(.ADDR_W(10), .ERR_CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_valid(o_valid), .i_out_ready(i_out_ready), .o_instr(o_instr), .o_addr(o_addr),
    .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  rv32i_encoder #(.ADDR_W(2), .ERR_CNT_W(16)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready2),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_valid(o_valid2), .i_out_ready(i_out_ready), .o_instr(o_instr2), .o_addr(o_addr2),
    .o_err(o_err2), .o_err_cnt(o_err_cnt2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Golden encoder written from the instruction-set rules with integer arithmetic.
  localparam int BR_F3[6]  = '{0, 1, 4, 5, 6, 7};
  localparam int LD_F3[5]  = '{0, 1, 2, 4, 5};
  localparam int AI_F3[6]  = '{0, 2, 3, 4, 6, 7};
  localparam int R_F3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  localparam int CSR_F3[6] = '{1, 2, 3, 5, 6, 7};

  function automatic logic [32:0] modelEncode(input int op, input int rd, input int rs1,
                                              input int rs2, input int imm);
    logic [31:0] w, u;
    bit bad;
    int f7;
    w = 0; bad = 0; u = 32'(imm);
    if (op == 0 || op == 1) begin
      bad = (imm < 0) || (imm >= (1 << 20));
      w = (u << 12) | (rd << 7) | ((op == 0) ? 'h37 : 'h17);
    end else if (op == 2) begin
      bad = (imm < -(1 << 20)) || (imm > (1 << 20) - 2) || (imm % 2 != 0);
      w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
        | (((u >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
    end else if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23)) begin
      bad = (imm < -2048) || (imm > 2047);
      w = ((u & 'hFFF) << 20) | (rs1 << 15) | (rd << 7);
      if (op == 3) w = w | 'h67;
      else if (op <= 14) w = w | (LD_F3[op - 10] << 12) | 'h03;
      else w = w | (AI_F3[op - 18] << 12) | 'h13;
    end else if (op >= 4 && op <= 9) begin
      bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
      w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
        | (BR_F3[op - 4] << 12) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | 'h63;
    end else if (op >= 15 && op <= 17) begin
      bad = (imm < -2048) || (imm > 2047);
      w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 15) << 12)
        | ((u & 'h1F) << 7) | 'h23;
    end else if (op >= 24 && op <= 26) begin
      bad = (imm < 0) || (imm > 31);
      f7 = (op == 26) ? 32 : 0;
      w = (f7 << 25) | (u << 20) | (rs1 << 15) | (((op == 24) ? 1 : 5) << 12) | (rd << 7) | 'h13;
    end else if (op >= 27 && op <= 36) begin
      f7 = (op == 28 || op == 34) ? 32 : 0;
      w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (R_F3[op - 27] << 12) | (rd << 7) | 'h33;
    end else if (op == 37) begin
      w = ((u & 'hFFF) << 20) | 'h0F;
    end else if (op == 38) begin
      w = 'h100F;
    end else if (op == 39) begin
      w = 'h73;
    end else if (op == 40) begin
      w = 'h0010_0073;
    end else if (op >= 41 && op <= 46) begin
      bad = (imm < 0) || (imm > 4095);
      w = (u << 20) | (rs1 << 15) | (CSR_F3[op - 41] << 12) | (rd << 7) | 'h73;
    end else begin
      bad = 1;
    end
    if (bad) w = 0;
    return {bad, w};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc;
  } ent_t;

  ent_t q[$];
  ent_t e;
  logic [32:0] enc;
  int   edge_n, last_pop, m_addr, m_cnt, vis;
  bit   m_valid, hs, acc;
  logic [31:0] m_instr;
  logic m_err;

  // Words become visible one edge after acceptance, or as soon as the word ahead leaves.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q.delete();
      edge_n = 0; last_pop = 0; m_addr = 0; m_cnt = 0;
      m_valid = 0; m_instr = 0; m_err = 0;
    end else begin
      edge_n++;
      hs  = m_valid && i_out_ready;
      acc = i_valid && !(m_valid && !i_out_ready);
      if (hs) begin
        if (q[0].err && m_cnt != 'hFFFF) m_cnt++;
        m_addr = (m_addr + 1) % 1024;
        void'(q.pop_front());
        last_pop = edge_n;
      end
      if (i_clear) begin
        m_addr = 0;
        m_cnt  = 0;
      end
      if (acc) begin
        enc = modelEncode(int'(i_op), int'(i_rd), int'(i_rs1), int'(i_rs2), int'($signed(i_imm)));
        e.instr = enc[31:0];
        e.err   = enc[32];
        e.acc   = edge_n;
        q.push_back(e);
      end
      m_valid = 0;
      if (q.size() > 0) begin
        vis = (q[0].acc + 1 > last_pop) ? q[0].acc + 1 : last_pop;
        if (edge_n >= vis) begin
          m_valid = 1;
          m_instr = q[0].instr;
          m_err   = q[0].err;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      checkOutput("o_valid", 32'(o_valid), 32'(m_valid));
      checkOutput("o_ready", 32'(o_ready), 32'(!(m_valid && !i_out_ready)));
      checkOutput("o_addr", 32'(o_addr), 32'(m_addr));
      checkOutput("o_err_cnt", 32'(o_err_cnt), 32'(m_cnt));
      checkOutput("o_valid_w2", 32'(o_valid2), 32'(m_valid));
      checkOutput("o_addr_w2", 32'(o_addr2), 32'(m_addr % 4));
      if (m_valid) begin
        checkOutput("o_instr", o_instr, m_instr);
        checkOutput("o_err", 32'(o_err), 32'(m_err));
      end
    end
  end

  bit toggle_ready = 0;
  always @(posedge i_clk) begin
    if (toggle_ready) begin
      #2;
      i_out_ready = ~i_out_ready;
    end
  end

  task automatic applyStimulus(input int op, input int rd, input int rs1, input int rs2, input int imm);
    bit took;
    int guard;
    i_op = 6'(op); i_rd = 5'(rd); i_rs1 = 5'(rs1); i_rs2 = 5'(rs2); i_imm = 32'(imm);
    i_valid = 1'b1;
    took = 0;
    guard = 0;
    while (!took && guard < 50) begin
      took = o_ready;
      @(negedge i_clk);
      guard++;
    end
    i_valid = 1'b0;
    if (!took) checkOutput("accept_timeout", 32'(guard), 32'(0));
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((q.size() != 0) && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    checkOutput("drain", 32'(q.size()), 32'(0));
    @(negedge i_clk);
  endtask

  task automatic pulseClear();
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
  endtask

  localparam int NB = 18;
  localparam int B_OP[NB]  = '{18, 18, 18, 18, 4, 4, 4, 2, 2, 2, 0, 0, 26, 26, 41, 41, 17, 17};
  localparam int B_IMM[NB] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, 1048574,
                               -1048576, 1048576, 'hFFFFF, 'h100000, 31, 32, 'hFFF, 'h1000,
                               -2048, 2048};

  logic [32:0] pin;

  initial begin
    i_rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_out_ready = 1'b1;
    i_op = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0;
    #1;
    checkOutput("rst_valid", 32'(o_valid), 32'(0));
    checkOutput("rst_instr", o_instr, 32'h0);
    checkOutput("rst_err", 32'(o_err), 32'(0));
    checkOutput("rst_addr", 32'(o_addr), 32'(0));
    checkOutput("rst_err_cnt", 32'(o_err_cnt), 32'(0));
    @(negedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);

    pin = modelEncode(18, 1, 0, 0, 5);   checkOutput("pin_addi", pin[31:0], 32'h0050_0093);
    pin = modelEncode(27, 3, 1, 2, 0);   checkOutput("pin_add", pin[31:0], 32'h0020_81B3);
    pin = modelEncode(17, 0, 1, 2, 4);   checkOutput("pin_sw", pin[31:0], 32'h0020_A223);
    pin = modelEncode(4, 0, 1, 2, 8);    checkOutput("pin_beq", pin[31:0], 32'h0020_8463);
    pin = modelEncode(0, 5, 0, 0, 'h12345); checkOutput("pin_lui", pin[31:0], 32'h1234_52B7);
    pin = modelEncode(4, 0, 1, 2, 7);    checkOutput("pin_beq_odd", 32'(pin[32]), 32'(1));

    applyStimulus(18, 1, 0, 0, 5);
    checkOutput("lat_early", 32'(o_valid), 32'(0));
    @(negedge i_clk);
    checkOutput("lat_valid", 32'(o_valid), 32'(1));
    checkOutput("lat_addi", o_instr, 32'h0050_0093);
    applyStimulus(27, 3, 1, 2, 0);
    applyStimulus(17, 0, 1, 2, 4);
    applyStimulus(4, 0, 1, 2, 8);
    applyStimulus(0, 5, 0, 0, 'h12345);
    waitIdle();

    pulseClear();
    applyStimulus(4, 0, 1, 2, 7);
    applyStimulus(18, 1, 0, 0, 4096);
    waitIdle();
    checkOutput("err_cnt_two", 32'(o_err_cnt), 32'(2));

    for (int op = 0; op < 64; op++) applyStimulus(op, 5, 6, 7, 12);
    waitIdle();
    for (int i = 0; i < NB; i++) applyStimulus(B_OP[i], 9, 10, 11, B_IMM[i]);
    waitIdle();

    pulseClear();
    toggle_ready = 1;
    for (int i = 0; i < 5; i++) applyStimulus(27 + i, i + 1, i + 2, i + 3, 0);
    waitIdle();
    toggle_ready = 0;
    i_out_ready = 1'b1;
    @(negedge i_clk);
    checkOutput("stream_addr", 32'(o_addr), 32'(5));
    checkOutput("stream_addr_w2", 32'(o_addr2), 32'(1));

    applyStimulus(21, 4, 4, 0, -1);
    applyStimulus(22, 4, 4, 0, 100);
    checkOutput("clr_keep_addr", 32'(o_addr), 32'(5));
    pulseClear();
    checkOutput("clr_next_valid", 32'(o_valid), 32'(1));
    checkOutput("clr_next_addr", 32'(o_addr), 32'(0));

    applyStimulus(3, 1, 2, 0, -4);
    applyStimulus(37, 0, 0, 0, 'h0FF);
    #1 i_rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(o_valid), 32'(0));
    checkOutput("midrst_addr", 32'(o_addr), 32'(0));
    checkOutput("midrst_err", 32'(o_err), 32'(0));
    @(negedge i_clk);
    #1 i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    applyStimulus(44, 7, 31, 0, 'h305);
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
